hazard_ctrl: RTL and testbench

- Pipeline hazard and bypass controller for the 5-stage core.
- Keeps a shadow scoreboard of destination registers in EX, MEM and WB.
- Drives the regfile bypass enables (EX_D_bp, MEM_D_bp, WB_D_bp).
- Sequences stalls (load-use, memory wait) and flushes on taken branches, so decode always sees correct operands.

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/hazard_match.sv | 20 ++
 rtl/hazard_ctrl.sv | 168 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard / bypass controller.
package hazard_pkg;

  // Controller state; the encoding is visible on state_o for debug.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    FLUSH    = 2'd3
  } hz_state_e;

  // Scoreboard slot layout: {valid, we, ld, rd}.
  localparam int unsigned SLOT_VALID_W = 1;
  localparam int unsigned SLOT_WE_W    = 1;
  localparam int unsigned SLOT_LD_W    = 1;
  localparam int unsigned NUM_SLOTS    = 3;

  // Slot indices, youngest first.
  localparam int unsigned SL_EX  = 0;
  localparam int unsigned SL_MEM = 1;
  localparam int unsigned SL_WB  = 2;

  // Bit positions inside each 2-bit bypass bus.
  localparam int unsigned BP_RA = 1;
  localparam int unsigned BP_RB = 0;

endpackage

// File: rtl/hazard_match.sv
// Compares one scoreboard slot against one decode-stage source operand.
module hazard_match #(
  parameter int unsigned ADDR_SIZE = 5,
  parameter int unsigned REG_NUM   = 32
) (
  input  logic                 slot_valid_i,
  input  logic                 slot_we_i,
  input  logic [ADDR_SIZE-1:0] slot_rd_i,
  input  logic [ADDR_SIZE-1:0] op_id_i,
  input  logic                 op_use_i,
  input  logic                 d_valid_i,
  output logic                 match_o
);

  // x0 is hard-wired zero and never a hazard source; IDs outside the file never match.
  assign match_o = slot_valid_i && slot_we_i && (slot_rd_i != '0) &&
                   (32'(slot_rd_i) < REG_NUM) && (slot_rd_i == op_id_i) &&
                   op_use_i && d_valid_i;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and bypass controller: shadow scoreboard of EX/MEM/WB
// destinations, bypass selection, stall/flush sequencing.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 5,
  parameter int unsigned REG_NUM   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 D_valid,
  input  logic [ADDR_SIZE-1:0] D_ra,
  input  logic [ADDR_SIZE-1:0] D_rb,
  input  logic                 D_use_ra,
  input  logic                 D_use_rb,
  input  logic [ADDR_SIZE-1:0] D_rd,
  input  logic                 D_we,
  input  logic                 D_ld,
  input  logic                 EX_brn_taken,
  input  logic                 MEM_busy,
  output logic [1:0]           EX_D_bp,
  output logic [1:0]           MEM_D_bp,
  output logic [1:0]           WB_D_bp,
  output logic                 F_stall,
  output logic                 D_stall,
  output logic                 D_flush,
  output logic                 EX_bubble,
  output logic [1:0]           state_o
);

  logic [NUM_SLOTS-1:0] valid_q, valid_d;
  logic [NUM_SLOTS-1:0] we_q, we_d;
  logic [NUM_SLOTS-1:0] ld_q, ld_d;
  logic [ADDR_SIZE-1:0] rd_q [NUM_SLOTS];
  logic [ADDR_SIZE-1:0] rd_d [NUM_SLOTS];

  logic [NUM_SLOTS-1:0] m_ra, m_rb;

  hz_state_e state_q, state_d;
  logic      load_use;
  logic      stall_c, flush_c, bubble_c;

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    hazard_match #(.ADDR_SIZE(ADDR_SIZE), .REG_NUM(REG_NUM)) u_match_ra (
      .slot_valid_i (valid_q[s]),
      .slot_we_i    (we_q[s]),
      .slot_rd_i    (rd_q[s]),
      .op_id_i      (D_ra),
      .op_use_i     (D_use_ra),
      .d_valid_i    (D_valid),
      .match_o      (m_ra[s])
    );
    hazard_match #(.ADDR_SIZE(ADDR_SIZE), .REG_NUM(REG_NUM)) u_match_rb (
      .slot_valid_i (valid_q[s]),
      .slot_we_i    (we_q[s]),
      .slot_rd_i    (rd_q[s]),
      .op_id_i      (D_rb),
      .op_use_i     (D_use_rb),
      .d_valid_i    (D_valid),
      .match_o      (m_rb[s])
    );
  end

  assign load_use = ld_q[SL_EX] && (m_ra[SL_EX] || m_rb[SL_EX]);

  // Bypass selection: youngest matching writer wins. A load still in EX blocks
  // older slots too, since their values are stale for that operand.
  always_comb begin
    EX_D_bp  = '0;
    MEM_D_bp = '0;
    WB_D_bp  = '0;
    if (!rst) begin
      EX_D_bp[BP_RA]  = m_ra[SL_EX] && !ld_q[SL_EX];
      EX_D_bp[BP_RB]  = m_rb[SL_EX] && !ld_q[SL_EX];
      MEM_D_bp[BP_RA] = m_ra[SL_MEM] && !m_ra[SL_EX];
      MEM_D_bp[BP_RB] = m_rb[SL_MEM] && !m_rb[SL_EX];
      WB_D_bp[BP_RA]  = m_ra[SL_WB] && !m_ra[SL_MEM] && !m_ra[SL_EX];
      WB_D_bp[BP_RB]  = m_rb[SL_WB] && !m_rb[SL_MEM] && !m_rb[SL_EX];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Next state: memory wait dominates, then branch flush, then load-use.
  // LU_STALL and FLUSH always hold a bubble in EX, so they only test MEM_busy.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN, MEM_WAIT: begin
        if (MEM_busy)          state_d = MEM_WAIT;
        else if (EX_brn_taken) state_d = FLUSH;
        else if (load_use)     state_d = LU_STALL;
        else                   state_d = RUN;
      end
      LU_STALL, FLUSH: state_d = MEM_busy ? MEM_WAIT : RUN;
      default:         state_d = RUN;
    endcase
  end

  // Control outputs for the current cycle, decoded like the next-state logic.
  always_comb begin
    stall_c  = 1'b0;
    flush_c  = 1'b0;
    bubble_c = 1'b0;
    unique case (state_q)
      RUN, MEM_WAIT: begin
        if (MEM_busy) begin
          stall_c = 1'b1;
        end else if (EX_brn_taken) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
        end else if (load_use) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
        end
      end
      LU_STALL, FLUSH: stall_c = MEM_busy;
      default: ;
    endcase
    F_stall   = stall_c && !rst;
    D_stall   = stall_c && !rst;
    D_flush   = flush_c && !rst;
    EX_bubble = bubble_c && !rst;
    state_o   = state_q;
  end

  // Scoreboard advance: held while memory is busy, EX takes a bubble on stall/flush.
  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    ld_d    = ld_q;
    rd_d    = rd_q;
    if (!MEM_busy) begin
      valid_d[SL_WB]  = valid_q[SL_MEM];
      we_d[SL_WB]     = we_q[SL_MEM];
      ld_d[SL_WB]     = ld_q[SL_MEM];
      rd_d[SL_WB]     = rd_q[SL_MEM];
      valid_d[SL_MEM] = valid_q[SL_EX];
      we_d[SL_MEM]    = we_q[SL_EX];
      ld_d[SL_MEM]    = ld_q[SL_EX];
      rd_d[SL_MEM]    = rd_q[SL_EX];
      valid_d[SL_EX]  = D_valid && !bubble_c;
      we_d[SL_EX]     = D_we;
      ld_d[SL_EX]     = D_ld;
      rd_d[SL_EX]     = D_rd;
    end
  end

  // Scoreboard registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      we_q    <= '0;
      ld_q    <= '0;
      rd_q    <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      ld_q    <= ld_d;
      rd_q    <= rd_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       D_valid;
  logic [4:0] D_ra, D_rb, D_rd;
  logic       D_use_ra, D_use_rb, D_we, D_ld;
  logic       EX_brn_taken, MEM_busy;
  logic [1:0] EX_D_bp, MEM_D_bp, WB_D_bp;
  logic       F_stall, D_stall, D_flush, EX_bubble;
  logic [1:0] state_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  hazard_ctrl #(.ADDR_SIZE(5), .REG_NUM(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .D_valid      (D_valid),
    .D_ra         (D_ra),
    .D_rb         (D_rb),
    .D_use_ra     (D_use_ra),
    .D_use_rb     (D_use_rb),
    .D_rd         (D_rd),
    .D_we         (D_we),
    .D_ld         (D_ld),
    .EX_brn_taken (EX_brn_taken),
    .MEM_busy     (MEM_busy),
    .EX_D_bp      (EX_D_bp),
    .MEM_D_bp     (MEM_D_bp),
    .WB_D_bp      (WB_D_bp),
    .F_stall      (F_stall),
    .D_stall      (D_stall),
    .D_flush      (D_flush),
    .EX_bubble    (EX_bubble),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // ctrl = {F_stall, D_stall, D_flush, EX_bubble}
  task automatic check_all(input string tag, input logic [1:0] ex, input logic [1:0] mem,
                           input logic [1:0] wb, input logic [3:0] ctrl, input logic [1:0] st);
    #1;
    check({tag, ".ex"},    {2'b00, EX_D_bp},  {2'b00, ex});
    check({tag, ".mem"},   {2'b00, MEM_D_bp}, {2'b00, mem});
    check({tag, ".wb"},    {2'b00, WB_D_bp},  {2'b00, wb});
    check({tag, ".ctrl"},  {F_stall, D_stall, D_flush, EX_bubble}, ctrl);
    check({tag, ".state"}, {2'b00, state_o},  {2'b00, st});
  endtask

  task automatic drive(input logic v, input logic [4:0] ra, input logic [4:0] rb,
                       input logic ura, input logic urb, input logic [4:0] rd,
                       input logic we, input logic ld);
    D_valid = v; D_ra = ra; D_rb = rb; D_use_ra = ura; D_use_rb = urb;
    D_rd = rd; D_we = we; D_ld = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    EX_brn_taken = 0;
    MEM_busy = 0;
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1;
    EX_brn_taken = 0;
    MEM_busy = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    check_all("rst.hold", 2'b00, 2'b00, 2'b00, 4'b0000, 2'd0);
    rst = 1'b0;
    tick();
    check_all("rst.rel", 2'b00, 2'b00, 2'b00, 4'b0000, 2'd0);

    // add x3 = x1 + x2 ; add x4 = x3 + x1
    drive(1, 1, 2, 1, 1, 3, 1, 0);
    check_all("alu.first", 2'b00, 2'b00, 2'b00, 4'b0000, 2'd0);
    tick();
    drive(1, 3, 1, 1, 1, 4, 1, 0);
    check_all("alu.b2b", 2'b10, 2'b00, 2'b00, 4'b0000, 2'd0);
    tick();
    drain();

    // ld x5 ; add x6 = x2 + x5
    drive(1, 2, 0, 1, 0, 5, 1, 1);
    tick();
    drive(1, 2, 5, 1, 1, 6, 1, 0);
    check_all("lu.detect", 2'b00, 2'b00, 2'b00, 4'b1101, 2'd0);
    tick();
    check_all("lu.stall", 2'b00, 2'b01, 2'b00, 4'b0000, 2'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_all("lu.after", 2'b00, 2'b00, 2'b00, 4'b0000, 2'd0);
    drain();

    // x7 written three times, then read on both ports as it moves down the pipe
    drive(1, 1, 0, 0, 0, 7, 1, 0);
    repeat (3) tick();
    drive(1, 7, 7, 1, 1, 8, 0, 0);
    check_all("tri.ex", 2'b11, 2'b00, 2'b00, 4'b0000, 2'd0);
    tick();
    check_all("tri.mem", 2'b00, 2'b11, 2'b00, 4'b0000, 2'd0);
    tick();
    check_all("tri.wb", 2'b00, 2'b00, 2'b11, 4'b0000, 2'd0);
    drain();

    // ld x0 followed by a reader of x0: no bypass, no load-use stall
    drive(1, 1, 0, 1, 0, 0, 1, 1);
    tick();
    drive(1, 0, 0, 1, 1, 9, 1, 0);
    check_all("x0.read", 2'b00, 2'b00, 2'b00, 4'b0000, 2'd0);
    drain();

    // branch taken with concurrent load-use, then MEM_busy for 3 cycles
    drive(1, 2, 0, 1, 0, 5, 1, 1);
    tick();
    drive(1, 2, 5, 1, 1, 6, 1, 0);
    EX_brn_taken = 1;
    check_all("br.lu", 2'b00, 2'b00, 2'b00, 4'b0011, 2'd0);
    tick();
    EX_brn_taken = 0;
    MEM_busy = 1;
    check_all("br.flush", 2'b00, 2'b01, 2'b00, 4'b1100, 2'd3);
    tick();
    check_all("br.wait1", 2'b00, 2'b01, 2'b00, 4'b1100, 2'd2);
    tick();
    check_all("br.wait2", 2'b00, 2'b01, 2'b00, 4'b1100, 2'd2);
    tick();
    MEM_busy = 0;
    check_all("br.wait3", 2'b00, 2'b01, 2'b00, 4'b0000, 2'd2);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_all("br.run", 2'b00, 2'b00, 2'b00, 4'b0000, 2'd0);
    drain();

    // taken branch held in EX across MEM_busy flushes on the first free cycle
    MEM_busy = 1;
    EX_brn_taken = 1;
    check_all("hold.busy", 2'b00, 2'b00, 2'b00, 4'b1100, 2'd0);
    tick();
    MEM_busy = 0;
    check_all("hold.flush", 2'b00, 2'b00, 2'b00, 4'b0011, 2'd2);
    tick();
    EX_brn_taken = 0;
    check_all("hold.fst", 2'b00, 2'b00, 2'b00, 4'b0000, 2'd3);
    tick();
    check_all("hold.run", 2'b00, 2'b00, 2'b00, 4'b0000, 2'd0);
    drain();

    // reset while in LU_STALL
    drive(1, 2, 0, 1, 0, 5, 1, 1);
    tick();
    drive(1, 2, 5, 1, 1, 6, 1, 0);
    check_all("rlu.detect", 2'b00, 2'b00, 2'b00, 4'b1101, 2'd0);
    tick();
    check_all("rlu.stall", 2'b00, 2'b01, 2'b00, 4'b0000, 2'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all("rlu.after", 2'b00, 2'b00, 2'b00, 4'b0000, 2'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
